// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier, signed 16x16 -> 32; operands arrive serially on data_in.
// Latency 18 cycles from start sample to done; done/result held until start drops.
module booth_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic        start,
  output logic [31:0] result,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_Q, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] m_q, m_d;
  logic [16:0] a_q, a_d;
  logic [15:0] q_q, q_d;
  logic        q1_q, q1_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [16:0] m_ext;
  logic [16:0] sum;

  assign m_ext  = {m_q[15], m_q};
  assign result = {a_q[15:0], q_q};

  always_comb begin
    case ({q_q[0], q1_q})
      2'b01:   sum = a_q + m_ext;
      2'b10:   sum = a_q - m_ext;
      default: sum = a_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_M;
      end
      LOAD_M: begin
        m_d     = data_in;
        a_d     = '0;
        q1_d    = 1'b0;
        cnt_d   = 5'd16;
        state_d = LOAD_Q;
      end
      LOAD_Q: begin
        q_d     = data_in;
        state_d = CALC;
      end
      CALC: begin
        // Arithmetic shift of {sum, Q, q_1}: sign of the 17-bit sum is replicated.
        a_d   = {sum[16], sum[16:1]};
        q_d   = {sum[0], q_q[15:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed cases, reset abort, restart and random pairs.
module tb_booth_multiplier;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic        start;
  logic [31:0] result;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] sb_q[$];

  booth_multiplier dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .start   (start),
    .result  (result),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Runs one multiplication with start held high; returns once done is seen (or budget expires).
  task automatic do_mul(input logic signed [15:0] a, input logic signed [15:0] b,
                        input bit timing_chk);
    int n;
    int lows;
    logic [31:0] exp;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    n = 0;
    @(negedge clk); data_in = a;
    @(negedge clk); data_in = b; n = 1;
    sb_q.push_back(32'(int'(a) * int'(b)));
    lows = 0;
    while (!done && n < 40) begin
      @(posedge clk); n++; #1;
      if (!done) lows++;
    end
    if (timing_chk) begin
      chk("latency", 32'(n), 32'd18);
      chk("done_low_calc", 32'(lows), 32'd16);
    end
    chk("done_hi", {31'd0, done}, 32'd1);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      chk($sformatf("prod %0d*%0d", a, b), result, exp);
    end
  endtask

  task automatic release_start();
    @(negedge clk); start = 1'b0;
  endtask

  initial begin
    int bad_hold;
    logic [31:0] held;
    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    #20;
    @(negedge clk); rst_n = 1'b1;

    do_mul(-16'sd10, 16'sd13, 1'b1);
    chk("neg130", result, 32'hFFFFFF7E);
    held = result;
    bad_hold = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done !== 1'b1 || result !== held) bad_hold++;
    end
    chk("hold_500ns", 32'(bad_hold), 32'd0);
    release_start();
    @(posedge clk); #1;
    chk("idle_after_drop", {31'd0, done}, 32'd0);

    do_mul(-16'sd32768, -16'sd32768, 1'b1);
    chk("minmin", result, 32'h40000000);
    release_start();
    do_mul(16'sd32767, -16'sd32768, 1'b0);
    chk("maxmin", result, 32'hC0008000);
    release_start();
    do_mul(16'sd0, 16'sd12345, 1'b0);
    release_start();
    do_mul(-16'sd1, -16'sd1, 1'b1);
    release_start();
    do_mul(16'sd7, -16'sd1, 1'b1);
    chk("seven_neg1", result, 32'hFFFFFFF9);
    release_start();

    // Abort mid-CALC at iteration 8 with an asynchronous reset.
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); data_in = 16'sd1234;
    @(negedge clk); data_in = -16'sd567;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_result", result, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("stay_idle_done", {31'd0, done}, 32'd0);
    chk("stay_idle_result", result, 32'd0);

    // Back-to-back with a single-cycle start drop.
    do_mul(16'sd5, 16'sd6, 1'b0);
    release_start();
    do_mul(16'sd100, -16'sd3, 1'b1);
    chk("neg300", result, 32'(-300));
    release_start();

    for (int i = 0; i < 1000; i++) begin
      do_mul(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'b0);
      release_start();
    end

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/booth_multiplier.md
# booth_multiplier

Sequential radix-2 Booth multiplier for signed 16-bit two's-complement operands, producing a signed 32-bit product. It is built as a datapath (multiplicand, accumulator and multiplier registers, adder/subtractor, shifter, counter) driven by a small control FSM. Both operands arrive serially on one shared 16-bit input bus after a start request. It serves as a standalone arithmetic unit; the host sequences operands and waits for `done`.

## Interface
- No parameters; operand width is fixed at 16, product width at 32.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `data_in` input 16: shared operand bus, signed; the multiplicand comes first, then the multiplier.
- `start` input 1: level request to begin a multiplication.
- `result` output 32: signed product, `{A[15:0], Q}`; valid while `done`=1.
- `done` output 1: high while the finished product is held.

## Operation
- Registers:
  - `M` (16, multiplicand).
  - `A` (17-bit signed accumulator; the extra bit absorbs the −(−32768) overflow).
  - `Q` (16, multiplier/low product).
  - `q_1` (1, Booth extension bit).
  - `cnt` (5).
- FSM states: IDLE, LOAD_M, LOAD_Q, CALC, DONE.
- **IDLE:** `done`=0. If `start`=1 at the edge, go to LOAD_M.
- **LOAD_M:** at the edge, `M`←`data_in`, `A`←0, `q_1`←0, `cnt`←16. Go to LOAD_Q.
- **LOAD_Q:** at the edge, `Q`←`data_in`. Go to CALC.
- **CALC** (one iteration per cycle):
  - Select the addend from `{Q[0], q_1}`: 01 → `A+M`, 10 → `A−M`, 00/11 → `A`. `M` is sign-extended to 17 bits.
  - Arithmetic right shift of `{A', Q, q_1}` by 1; the `A` MSB is replicated. Result goes to `{A, Q, q_1}`.
  - `cnt`←`cnt`−1. When `cnt` was 1, go to DONE.
- **DONE:**
  - `done`=1 and all registers hold, so `result` is stable.
  - Stay in DONE while `start`=1. Return to IDLE when `start`=0.
  - A new operation therefore requires `start` to be deasserted and then reasserted.
- `start` is ignored outside IDLE and DONE; `data_in` is ignored outside LOAD_M and LOAD_Q.
- `result` is driven combinationally from `{A[15:0], Q}` at all times. It shows intermediate values during CALC; only the DONE value is specified.
- The product is exact for all 2^32 operand pairs, including −32768 × −32768 = 0x40000000.

## Timing
- Reset (`rst_n`=0, asynchronous, any state including mid-CALC):
  - State goes to IDLE.
  - `M`, `A`, `Q`, `q_1`, `cnt` go to 0.
  - `result`=0 and `done`=0 immediately.
- Take edge E as the edge where `start`=1 is sampled in IDLE:
  - Multiplicand is captured at E+1.
  - Multiplier is captured at E+2.
  - 16 CALC iterations occur at edges E+3…E+18.
  - `done` rises after E+18, a latency of 18 cycles from the start sample.
- The host must present the multiplicand on `data_in` before edge E+1 and the multiplier before edge E+2. Changing `data_in` on falling edges satisfies this.
- `done` and `result` remain stable until `start` is sampled 0 in DONE; one cycle later `done`=0 in IDLE.
- Minimum restart: with `start` dropped for one edge and then raised, the next sample in IDLE begins a new operation.

## Test plan
- Reset released; `start`=1 at a falling edge, `data_in`=−10 at the next falling edge, 13 at the following one, `start` held high → `done`=1 after 18 cycles, `result`=−130 (0xFFFFFF7E); `done` stays high and `result` is unchanged for 500 ns with no restart.
- −32768 × −32768 → `result`=0x40000000; 32767 × −32768 → 0xC0008000; 0 × 12345 → 0.
- −1 × −1 → 1; 7 × −1 → 0xFFFFFFF9; verify that `done` is 0 during all 16 CALC cycles.
- Assert `rst_n`=0 during CALC (iteration 8) → `result`=0 and `done`=0 asynchronously; after release with `start`=0 the block stays IDLE.
- Back-to-back: after `done`, drop `start` for one cycle, then run 100 × −3 → `done` 18 cycles after the new start sample, `result`=−300.
- Randomized: 1000 random signed pairs checked against the reference product at `done`.
